// File: rtl/register_file_pkg.sv
// register_file_pkg: default sizes and shared typedefs for the scoreboard register file.
package register_file_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int DEPTH_DEF = 16;
   typedef logic [$clog2(DEPTH_DEF)-1:0] reg_addr_t;
   typedef logic [WIDTH_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: address decode, mux, optional forwarding and output register for one read port.
// REGFILE_BYPASS_EN forwards same-cycle write data and post-edge busy state.
module regfile_read_port
   import register_file_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int ABITS = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable_n,
   input  logic [ABITS-1:0]       read_addr,
   input  logic [DEPTH*WIDTH-1:0] regs_flat,
   input  logic [DEPTH-1:0]       busy_pre,
   input  logic [DEPTH-1:0]       busy_post,
   input  logic                   wr_en,
   input  logic [ABITS-1:0]       wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       read_data,
   output logic                   read_busy
);
   logic [WIDTH-1:0] read_data_q, read_data_d, sel_data;
   logic             read_busy_q, read_busy_d, sel_busy;
   logic             unused;
`ifdef REGFILE_BYPASS_EN
   // wr_en already excludes r0 and disabled cycles
   assign sel_data = (wr_en && wr_addr == read_addr) ? wr_data : regs_flat[int'(read_addr)*WIDTH +: WIDTH];
   assign sel_busy = busy_post[read_addr];
   assign unused   = ^busy_pre;
`else
   assign sel_data = regs_flat[int'(read_addr)*WIDTH +: WIDTH];
   assign sel_busy = busy_pre[read_addr];
   assign unused   = ^{busy_post, wr_en, wr_addr, wr_data};
`endif
   always_comb begin
      read_data_d = enable_n ? read_data_q : sel_data;
      read_busy_d = enable_n ? read_busy_q : sel_busy;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_data_q <= '0;
         read_busy_q <= 1'b0;
      end else begin
         read_data_q <= read_data_d;
         read_busy_q <= read_busy_d;
      end
   end
   assign read_data = read_data_q;
   assign read_busy = read_busy_q;
endmodule

// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file: register file with per-register busy bits, two registered read ports.
// REGFILE_BYPASS_EN enables write-to-read forwarding in the read ports.
module scoreboard_register_file
   import register_file_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int ABITS = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable_n,
   input  logic             write_en,
   input  logic [ABITS-1:0] write_addr,
   input  logic [WIDTH-1:0] write_data,
   input  logic             reserve_en,
   input  logic [ABITS-1:0] reserve_addr,
   input  logic             flush,
   input  logic [ABITS-1:0] read_addr_a,
   input  logic [ABITS-1:0] read_addr_b,
   output logic [WIDTH-1:0] read_data_a,
   output logic [WIDTH-1:0] read_data_b,
   output logic             read_busy_a,
   output logic             read_busy_b,
   output logic [ABITS:0]   busy_count
);
   logic [WIDTH-1:0]       regs_q [DEPTH];
   logic [WIDTH-1:0]       regs_d [DEPTH];
   logic [DEPTH-1:0]       busy_q, busy_d;
   logic [ABITS:0]         busy_count_q, busy_count_d;
   logic [DEPTH*WIDTH-1:0] regs_flat;
   logic                   wr, rsv;
   assign wr  = !enable_n && write_en && write_addr != '0;
   assign rsv = !enable_n && reserve_en && reserve_addr != '0;
   // flush is applied last so it beats a same-cycle reserve; reserve beats write
   always_comb begin
      regs_d       = regs_q;
      busy_d       = busy_q;
      busy_count_d = busy_count_q;
      if (wr) begin
         regs_d[write_addr] = write_data;
         busy_d[write_addr] = 1'b0;
      end
      if (rsv) busy_d[reserve_addr] = 1'b1;
      if (!enable_n && flush) busy_d = '0;
      busy_d[0] = 1'b0;
      if (!enable_n) begin
         busy_count_d = '0;
         for (int i = 0; i < DEPTH; i++) busy_count_d = busy_count_d + {{ABITS{1'b0}}, busy_d[i]};
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_q       <= '{default: '0};
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end
   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
   end
   regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_a (
      .clk(clk), .reset_n(reset_n), .enable_n(enable_n), .read_addr(read_addr_a),
      .regs_flat(regs_flat), .busy_pre(busy_q), .busy_post(busy_d),
      .wr_en(wr), .wr_addr(write_addr), .wr_data(write_data),
      .read_data(read_data_a), .read_busy(read_busy_a)
   );
   regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_b (
      .clk(clk), .reset_n(reset_n), .enable_n(enable_n), .read_addr(read_addr_b),
      .regs_flat(regs_flat), .busy_pre(busy_q), .busy_post(busy_d),
      .wr_en(wr), .wr_addr(write_addr), .wr_data(write_data),
      .read_data(read_data_b), .read_busy(read_busy_b)
   );
   assign busy_count = busy_count_q;
endmodule
